multicycle_controller: RTL

- Multi-cycle sequencer for the RV32 core: owns PC/IR write enables, regfile write strobe and the instruction/data memory handshakes.
- Sits beside the decode stage. It reads opcode[6:0] from the registered instruction and steps one instruction through FETCH, DECODE, EXECUTE, MEM and WB.
- Detects illegal opcodes and memory timeouts, then parks in a sticky FAULT state.

---
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Handshake bundle between the multi-cycle sequencer (master) and the
// datapath/memory side (slave).
interface multicycle_controller_if;
  logic       run;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_req;
  logic       imem_ack;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic       instr_retired;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  modport master (
    input  run, opcode, branch_taken, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           reg_write, instr_retired, fault, fault_code, state
  );

  modport slave (
    output run, opcode, branch_taken, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           reg_write, instr_retired, fault, fault_code, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// RV32 multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WB with sticky FAULT.
// Optional perf counters when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_controller #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_controller_if.master bus
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [WIDTH-1:0] cycle_count,
  output logic [WIDTH-1:0] instret_count
`endif
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Counter value during request cycle n is n-1, so the last allowed cycle sees LIMIT.
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        st;
  logic [1:0]    fcode;
  logic          is_store;
  logic [CW-1:0] wait_cnt;

  logic is_alu, is_mem, is_branch, legal, timeout;
  logic retire_br, retire_st, retire_wb, retire;

  always_comb begin
    is_alu    = (bus.opcode == OP_R) || (bus.opcode == OP_I);
    is_mem    = (bus.opcode == OP_LD) || (bus.opcode == OP_ST);
    is_branch = (bus.opcode == OP_BR);
    legal     = is_alu || is_mem || is_branch;
    timeout   = (MEM_TIMEOUT != 0) && (wait_cnt == LIMIT);
    retire_br = (st == S_EXEC) && is_branch;
    retire_st = (st == S_MEM) && bus.dmem_ack && is_store;
    retire_wb = (st == S_WB);
    retire    = retire_br || retire_st || retire_wb;
  end

  always_comb begin
    bus.imem_req      = (st == S_FETCH);
    bus.dmem_req      = (st == S_MEM);
    bus.dmem_we       = (st == S_MEM) && is_store;
    bus.fault         = (st == S_FAULT);
    bus.fault_code    = fcode;
    bus.state         = st;
    bus.ir_write      = (st == S_FETCH) && bus.imem_ack;
    bus.pc_write      = retire;
    bus.pc_src        = retire_br && bus.branch_taken;
    bus.reg_write     = retire_wb;
    bus.instr_retired = retire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      fcode    <= 2'b00;
      is_store <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (st)
        S_IDLE: if (bus.run) begin
          st       <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          if (bus.imem_ack) st <= S_DECODE;
          else if (timeout) begin
            st    <= S_FAULT;
            fcode <= 2'b10;
          end else if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: begin
          if (legal) begin
            st       <= S_EXEC;
            is_store <= (bus.opcode == OP_ST);
          end else begin
            st    <= S_FAULT;
            fcode <= 2'b01;
          end
        end
        S_EXEC: begin
          if (is_alu) st <= S_WB;
          else if (is_mem) begin
            st       <= S_MEM;
            wait_cnt <= '0;
          end else begin
            st       <= bus.run ? S_FETCH : S_IDLE;
            wait_cnt <= '0;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (is_store) begin
              st       <= bus.run ? S_FETCH : S_IDLE;
              wait_cnt <= '0;
            end else st <= S_WB;
          end else if (timeout) begin
            st    <= S_FAULT;
            fcode <= 2'b11;
          end else if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end
        S_WB: begin
          st       <= bus.run ? S_FETCH : S_IDLE;
          wait_cnt <= '0;
        end
        S_FAULT: st <= S_FAULT;
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (st != S_IDLE && st != S_FAULT) cycle_count <= cycle_count + 1'b1;
      if (retire) instret_count <= instret_count + 1'b1;
    end
  end
`endif
endmodule
